// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8-bit UART transmitter (8N1 by default).
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit (11-bit frame instead of 10).
//
// Parameters
//   CLK_FREQ   clk frequency in Hz
//   BAUD       serial bit rate; CLKS_PER_BIT = round(CLK_FREQ / BAUD), >= 4
//   FIFO_DEPTH byte queue depth, power of two in 2..64
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   we_i     write strobe, one byte per cycle while high (dropped when full)
//   wdata_i  byte to enqueue
//   full_o   FIFO holds FIFO_DEPTH bytes
//   empty_o  FIFO holds no bytes
//   level_o  bytes queued, excluding the byte being shifted out
//   busy_o   a frame is on the line
//   tx_o     registered serial line, idle high
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_i,
  input  logic [7:0]                  wdata_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        busy_o,
  output logic                        tx_o
);

  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   LVL_FULL   = (AW + 1)'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 4) begin : g_chk_baud
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 4");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..64");
  end

`ifdef UART_TX_PARITY_EN
  localparam int unsigned SW = 3;
`else
  localparam int unsigned SW = 2;
`endif
  localparam logic [SW-1:0] S_IDLE   = SW'(0);
  localparam logic [SW-1:0] S_START  = SW'(1);
  localparam logic [SW-1:0] S_DATA   = SW'(2);
  localparam logic [SW-1:0] S_STOP   = SW'(3);
`ifdef UART_TX_PARITY_EN
  localparam logic [SW-1:0] S_PARITY = SW'(4);
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q;
  logic          wr_en, pop, bit_done, line_bit;

  assign full_o  = (count_q == LVL_FULL);
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign busy_o  = (state_q != S_IDLE);
  assign tx_o    = tx_q;

  // A full FIFO drops the write even when a pop frees a slot in the same cycle.
  assign wr_en    = we_i && !full_o;
  assign bit_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_o) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          idx_d = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next frame when a byte is waiting.
        if (bit_done) begin
          if (!empty_o) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bit timer idles at zero and restarts at every bit boundary.
    cnt_d  = (state_q == S_IDLE || bit_done) ? '0 : cnt_q + CW'(1);
    data_d = pop ? mem[rd_ptr_q] : data_q;

    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Line value of the current state; registered into tx_q so the pin only
  // changes on clock edges.
  always_comb begin
    line_bit = 1'b1;
    case (state_q)
      S_START:  line_bit = 1'b0;
      S_DATA:   line_bit = data_q[idx_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_bit = ^data_q;
`endif
      default:  line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      tx_q     <= line_bit;
    end
  end

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning byte queue depth; power of two, 2..64.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port we_i  input  1  write strobe; one byte per cycle in which it is high.
REQ-007 SHALL have port wdata_i  input  8  byte to enqueue.
REQ-008 SHALL have port full_o  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-009 SHALL have port empty_o  output  1  FIFO holds zero bytes.
REQ-010 SHALL have port level_o  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted.
REQ-011 SHALL have port busy_o  output  1  a frame is on the line.
REQ-012 SHALL have port tx_o  output  1  serial line; idle high.

Function
REQ-013 SHALL derive CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD: 434 at defaults. Elaboration SHALL fail if the result is below 4.
REQ-014 SHALL accept the write in a cycle with we_i=1 and full_o=0; level_o increments at the next edge.
REQ-015 SHALL silently drop the write in a cycle with we_i=1 and full_o=1, with no state change, even if a pop occurs in the same cycle.
REQ-016 SHALL, on a simultaneous accepted write and pop, leave level_o unchanged, with the read and write pointers each advancing modulo FIFO_DEPTH.
REQ-017 SHALL implement a transmit FSM with states IDLE, START, DATA, STOP (plus PARITY per REQ-030).
REQ-018 SHALL, in IDLE with empty_o=0, pop the head byte into an 8-bit shift register and enter START at the next edge.
- A byte written into an empty FIFO while in IDLE drives tx_o low exactly 2 clk edges after the write edge.
REQ-019 SHALL hold each line bit for exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads on every state change.
REQ-020 SHALL drive tx_o=0 in START.
REQ-021 SHALL, in DATA, drive the 8 data bits LSB first, using a 3-bit index that wraps 7->0 on exit to the next state.
REQ-022 SHALL drive tx_o=1 in STOP; the stop bit is exactly one bit long.
REQ-023 SHALL, in the last cycle of STOP with empty_o=0, pop the next byte and enter START with no idle cycle between frames; otherwise it SHALL enter IDLE.
REQ-024 SHALL drive busy_o=1 in every state except IDLE, and drive tx_o=1 in IDLE.
REQ-025 SHALL register tx_o; it SHALL never glitch between bit boundaries.

Reset
REQ-026 SHALL, on rst_n=0, immediately set tx_o=1, busy_o=0, empty_o=1, full_o=0, level_o=0, FSM=IDLE, and pointers and counters to 0.
REQ-027 SHALL, on reset asserted mid-frame, abort the frame and discard queued bytes; the line stays high until a new write after reset release.
REQ-028 SHALL leave FIFO storage contents unreset; only the valid state is cleared.

Configuration
REQ-029 SHALL be controlled by macro UART_TX_PARITY_EN.
REQ-030 SHALL, with UART_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; the frame is 11 bits.
REQ-031 SHALL, without UART_TX_PARITY_EN, have no PARITY state or logic; the frame is 10 bits (8N1), matching the existing receiver.

Verification (CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10, unless stated)
REQ-032 SHALL pass this scenario: write 0x55 after reset -> tx_o low 2 edges after the write, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, high stop, busy_o low 100 cycles after the start edge.
REQ-033 SHALL pass this scenario: write 0xA3, 0x0F, 0xFF on consecutive cycles -> three back-to-back frames with no idle gap; level_o reads 2 after the first pop and reaches 0 once the third byte is popped.
REQ-034 SHALL pass this scenario: FIFO_DEPTH=8, 10 consecutive writes 0x00..0x09 while line busy -> full_o=1 after the 9th write; 0x09 dropped; bytes 0x00..0x08 transmitted in order.
REQ-035 SHALL pass this scenario: rst_n pulsed low during data bit 4 of 0xC3 -> tx_o=1 within the reset cycle; empty_o=1 and busy_o=0; no further transitions until the next write.
REQ-036 SHALL pass this scenario: UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 then stop bit; write 0x03 -> parity bit 0; frame length 110 cycles.
REQ-037 SHALL pass this scenario: loopback tx_o into the existing async receiver at defaults (434 clks/bit), 256 random bytes -> all received in order with no framing loss.
